// File: rtl/muxn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muxn_pkg                                                     |
// | Description : Shared mode encoding and limits for the N-channel selector. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package muxn_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    localparam int MAX_NCH = 16;

endpackage
`default_nettype wire

// File: rtl/muxn_rr_stream_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational rotate-scan arbiter starting after ptr.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    localparam logic [SELW:0] c_nch = (SELW+1)'(NCH);

    logic [SELW:0] w_sum;

    // Scan ptr+1 .. ptr+NCH; the last step revisits ptr itself so a lone
    // requester keeps winning.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        w_sum   = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_sum = {1'b0, ptr} + (SELW+1)'(k);
            if (w_sum >= c_nch) begin
                w_sum = w_sum - c_nch;
            end
            if (en && !gnt_vld && req[w_sum[SELW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_sum[SELW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/muxn_rr_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muxn_rr_stream                                               |
// | Description : N-channel valid/ready stream selector, fixed or round-robin.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muxn_rr_stream
    import muxn_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [NCH-1:0][WIDTH-1:0] in_data,
    input  logic [NCH-1:0]            in_valid,
    output logic [NCH-1:0]            in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SELW:0] c_nch = (SELW+1)'(NCH);

    logic [WIDTH-1:0]     r_out_data;
    logic [SELW-1:0]      r_out_ch;
    logic                 r_out_valid;
    logic [SELW-1:0]      r_ptr;

    logic                 w_load_ok;
    logic                 w_fixed_ok;
    logic [2**SELW-1:0]   w_valid_ext;
    logic                 w_rr_vld;
    logic [SELW-1:0]      w_rr_idx;
    logic                 w_gnt_vld;
    logic [SELW-1:0]      w_gnt_idx;
    logic [NCH-1:0]       w_ready;

    assign w_load_ok = !r_out_valid || out_ready;

    // Zero-extended so an out-of-range sel reads a 0 valid bit.
    always_comb begin
        w_valid_ext          = '0;
        w_valid_ext[NCH-1:0] = in_valid;
    end

    assign w_fixed_ok = ({1'b0, sel} < c_nch) && w_valid_ext[sel];

    rr_arbiter #(
        .NCH     (NCH)
    ) u_arb (
        .req     (in_valid),
        .ptr     (r_ptr),
        .en      (w_load_ok && (mode == MODE_RR)),
        .gnt_vld (w_rr_vld),
        .gnt_idx (w_rr_idx)
    );

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (mode == MODE_RR) begin
            w_gnt_vld = w_rr_vld;
            w_gnt_idx = w_rr_idx;
        end else if (w_load_ok && w_fixed_ok) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = sel;
        end
    end

    always_comb begin
        w_ready = '0;
        if (rst_n && w_gnt_vld) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= SELW'(NCH - 1);
        end else if (w_gnt_vld) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_gnt_idx];
            r_out_ch    <= w_gnt_idx;
            r_ptr       <= w_gnt_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_muxn_rr_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_muxn_rr_stream                                            |
// | Description : Directed scoreboard bench for muxn_rr_stream (NCH=4 and 5). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_muxn_rr_stream;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode;
    logic [1:0]       sel;
    logic [3:0][7:0]  in_data;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [7:0]       out_data;
    logic [1:0]       out_ch;
    logic             out_valid;
    logic             out_ready;

    logic [2:0]       sel5;
    logic [4:0][7:0]  in_data5;
    logic [4:0]       in_ready5;
    logic [7:0]       out_data5;
    logic [2:0]       out_ch5;
    logic             out_valid5;

    int               tests = 0;
    int               fails = 0;
    int               vec_n = 0;
    bit               run = 1'b0;
    bit               last_rst = 1'b0;
    logic [9:0]       exp_q[$];

    always #5 clk = ~clk;

    muxn_rr_stream #(.WIDTH(8), .NCH(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Second instance: non-power-of-2 channel count with out-of-range sel.
    muxn_rr_stream #(.WIDTH(8), .NCH(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (1'b0),
        .sel       (sel5),
        .in_data   (in_data5),
        .in_valid  (5'b11111),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_ch    (out_ch5),
        .out_valid (out_valid5),
        .out_ready (1'b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, vec_n, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented word must match the queue head.
    always @(negedge clk) begin
        if (run && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word (vec %0d): got ch %0d data %0h, none expected",
                         vec_n, out_ch, out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q[0][9:2]));
                chk("out_ch", 32'(out_ch), 32'(exp_q[0][1:0]));
                if (out_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input bit r, input bit m, input logic [1:0] s, input logic [3:0] v,
                        input logic [7:0] tag, input bit o, input logic [3:0] er,
                        input bit eov, input bit p, input logic [7:0] ed,
                        input logic [1:0] ec, input bit c0);
        if (last_rst) begin
            exp_q.delete();
        end
        rst_n     = r;
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = o;
        for (int i = 0; i < 4; i++) begin
            in_data[i] = tag + 8'(i);
        end
        sel5 = 3'(5 + (vec_n % 3));
        if (p) begin
            exp_q.push_back({ed, ec});
        end
        last_rst = !r;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(eov));
        if (c0) begin
            chk("reset_out_data", 32'(out_data), 32'h0);
            chk("reset_out_ch", 32'(out_ch), 32'h0);
        end
        chk("n5_in_ready", 32'(in_ready5), 32'h0);
        chk("n5_out_valid", 32'(out_valid5), 32'h0);
        @(posedge clk);
        #1;
        vec_n++;
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'hF;
        in_data   = '0;
        out_ready = 1'b1;
        sel5      = 3'd5;
        for (int i = 0; i < 5; i++) begin
            in_data5[i] = 8'hC0 + 8'(i);
        end
        @(posedge clk);
        #1;
        run = 1'b1;
        //   r m s  valid  tag   o  exp_rdy ov p  data   ch c0
        step(0,1,0, 4'hF, 8'h00, 1, 4'h0,   0, 0, 8'h00, 0, 1);
        // round-robin from reset: 0,1,2,3,0,1
        step(1,1,0, 4'hF, 8'h10, 1, 4'h1,   0, 1, 8'h10, 0, 0);
        step(1,1,0, 4'hF, 8'h10, 1, 4'h2,   1, 1, 8'h11, 1, 0);
        step(1,1,0, 4'hF, 8'h10, 1, 4'h4,   1, 1, 8'h12, 2, 0);
        step(1,1,0, 4'hF, 8'h10, 1, 4'h8,   1, 1, 8'h13, 3, 0);
        step(1,1,0, 4'hF, 8'h10, 1, 4'h1,   1, 1, 8'h10, 0, 0);
        step(1,1,0, 4'hF, 8'h10, 1, 4'h2,   1, 1, 8'h11, 1, 0);
        // back-pressure holding 8'h11, then drain+load same cycle
        step(1,1,0, 4'hF, 8'h20, 0, 4'h0,   1, 0, 8'h00, 0, 0);
        step(1,1,0, 4'hF, 8'h20, 0, 4'h0,   1, 0, 8'h00, 0, 0);
        step(1,1,0, 4'hF, 8'h20, 0, 4'h0,   1, 0, 8'h00, 0, 0);
        step(1,1,0, 4'hF, 8'h20, 1, 4'h4,   1, 1, 8'h22, 2, 0);
        // RR grants ch1, FIXED sel=3, back to RR resumes after last grant
        step(1,1,0, 4'h2, 8'h30, 1, 4'h2,   1, 1, 8'h31, 1, 0);
        step(1,0,3, 4'hF, 8'h40, 1, 4'h8,   1, 1, 8'h43, 3, 0);
        step(1,1,0, 4'hF, 8'h50, 1, 4'h1,   1, 1, 8'h50, 0, 0);
        // single requester wins repeatedly
        step(1,1,0, 4'h4, 8'h60, 1, 4'h4,   1, 1, 8'h62, 2, 0);
        step(1,1,0, 4'h4, 8'h70, 1, 4'h4,   1, 1, 8'h72, 2, 0);
        // FIXED on an idle channel: drain then empty
        step(1,0,2, 4'hB, 8'h80, 1, 4'h0,   1, 0, 8'h00, 0, 0);
        step(1,0,2, 4'hB, 8'h80, 1, 4'h0,   0, 0, 8'h00, 0, 0);
        // load then reset mid-stream
        step(1,1,0, 4'hF, 8'h90, 0, 4'h8,   0, 1, 8'h93, 3, 0);
        step(0,1,0, 4'hF, 8'h90, 0, 4'h0,   1, 0, 8'h00, 0, 0);
        step(1,1,0, 4'h0, 8'h00, 1, 4'h0,   0, 0, 8'h00, 0, 1);
        step(1,1,0, 4'hF, 8'hA0, 1, 4'h1,   0, 1, 8'hA0, 0, 0);
        step(1,1,0, 4'h0, 8'h00, 1, 4'h0,   1, 0, 8'h00, 0, 0);
        step(1,1,0, 4'h0, 8'h00, 1, 4'h0,   0, 0, 8'h00, 0, 0);
        run = 1'b0;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
